// File: rtl/pattern_seq_pkg.sv
// Shared types and constants for the table-driven pattern sequencer.
// Also used by pattern_seq_ctrl_if and ms_tick_gen.
package pattern_seq_pkg;

  localparam int unsigned TICK_COUNT_DEF = 27000;
  localparam int unsigned SEG_DUR_W      = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef struct packed {
    logic                 level;
    logic [SEG_DUR_W-1:0] dur;
  } segment_t;

  // Index width that stays at least one bit wide for degenerate sizes.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pattern_seq_ctrl_if.sv
// Configuration, control and status bundle of pattern_seq_ctrl.
// master = firmware or parent FSM; slave = the sequencer itself.
interface pattern_seq_ctrl_if
  import pattern_seq_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DUR_W  = SEG_DUR_W,
  parameter int unsigned LOOP_W = 4
);

  localparam int unsigned AW = idx_w(DEPTH);
  localparam int unsigned NW = $clog2(DEPTH + 1);

  logic              cfg_we;
  logic [AW-1:0]     cfg_addr;
  logic              cfg_level;
  logic [DUR_W-1:0]  cfg_dur;
  logic [NW-1:0]     num_seg;
  logic [LOOP_W-1:0] loops;
  logic              start;
  logic              stop;
  logic              sig;
  logic              busy;
  logic              done;
  logic [AW-1:0]     seg_idx;

  modport master (
    output cfg_we, cfg_addr, cfg_level, cfg_dur, num_seg, loops, start, stop,
    input  sig, busy, done, seg_idx
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_level, cfg_dur, num_seg, loops, start, stop,
    output sig, busy, done, seg_idx
  );

endinterface

// File: rtl/pattern_seq_ctrl_ms_tick_gen.sv
// Millisecond prescaler: counts 0..TICK_COUNT-1 while enabled and flags
// the last count with a one-cycle tick. clr restarts the millisecond.
module ms_tick_gen
  import pattern_seq_pkg::*;
#(
  parameter int unsigned TICK_COUNT = TICK_COUNT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned   PW   = idx_w(TICK_COUNT);
  localparam logic [PW-1:0] LAST = PW'(TICK_COUNT - 1);

  logic [PW-1:0] cnt_q;

  assign tick = en && (cnt_q == LAST);

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/pattern_seq_ctrl.sv
// Table-driven timed-pattern sequencer: plays {level, ms} segments on sig.
// Define PATTERN_SEQ_LOOP_EN to honour the loops (extra repetitions) input.
module pattern_seq_ctrl
  import pattern_seq_pkg::*;
#(
  parameter int unsigned TICK_COUNT = TICK_COUNT_DEF,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned DUR_W      = SEG_DUR_W,
  parameter int unsigned LOOP_W     = 4
) (
  input logic              clk,
  input logic              rst_n,
  pattern_seq_ctrl_if.slave seq
);

  localparam int unsigned   AW      = idx_w(DEPTH);
  localparam int unsigned   NW      = $clog2(DEPTH + 1);
  localparam logic [NW-1:0] DEPTH_N = NW'(DEPTH);

  segment_t         seg_tab_q [DEPTH];
  state_t           state_q, state_d;
  logic [AW-1:0]    seg_idx_q, seg_idx_d;
  logic [DUR_W-1:0] ms_q, ms_d;
  logic [NW-1:0]    nseg_q, nseg_d;
  logic             sig_q, sig_d;

  segment_t         cur;
  logic [AW-1:0]    nxt_idx;
  logic [DUR_W-1:0] last_ms;
  logic             tick, tick_clr, tick_en;
  logic             seg_end, last_seg, start_ok, loop_more;

  // The table is frozen while busy, so it can be read combinationally.
  assign cur      = seg_tab_q[seg_idx_q];
  assign nxt_idx  = seg_idx_q + 1'b1;
  assign last_ms  = (cur.dur == '0) ? '0 : cur.dur - 1'b1;
  assign seg_end  = tick && (ms_q == last_ms);
  assign last_seg = ((NW'(seg_idx_q) + 1'b1) == nseg_q);
  assign start_ok = seq.start && !seq.stop &&
                    (seq.num_seg != '0) && (seq.num_seg <= DEPTH_N);
  assign tick_en  = (state_q == RUN);

  ms_tick_gen #(
    .TICK_COUNT (TICK_COUNT)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tick_clr),
    .en    (tick_en),
    .tick  (tick)
  );

  // NOTE: the segment table is plain storage with no reset; its contents
  // survive rst_n so a parent FSM can restart without reprogramming.
  always_ff @(posedge clk) begin
    if (seq.cfg_we && (state_q != RUN)) begin
      seg_tab_q[seq.cfg_addr] <= '{level: seq.cfg_level, dur: seq.cfg_dur};
    end
  end

`ifdef PATTERN_SEQ_LOOP_EN
  logic [LOOP_W-1:0] loop_q, loop_d;

  assign loop_more = (loop_q != '0);

  always_comb begin
    loop_d = loop_q;
    if ((state_q == IDLE) && start_ok) begin
      loop_d = seq.loops;
    end else if ((state_q == RUN) && !seq.stop && seg_end && last_seg && loop_more) begin
      loop_d = loop_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      loop_q <= '0;
    end else begin
      loop_q <= loop_d;
    end
  end
`else
  logic unused_loops;

  assign unused_loops = ^seq.loops;
  assign loop_more    = 1'b0;
`endif

  // NOTE: every combinational output gets a default first, so no path
  // through the case statement can leave a value held (no latches).
  always_comb begin
    state_d   = state_q;
    seg_idx_d = seg_idx_q;
    ms_d      = ms_q;
    nseg_d    = nseg_q;
    sig_d     = sig_q;
    tick_clr  = 1'b0;

    unique case (state_q)
      IDLE: begin
        sig_d = 1'b0;
        if (start_ok) begin
          state_d   = RUN;
          nseg_d    = seq.num_seg;
          seg_idx_d = '0;
          ms_d      = '0;
          sig_d     = seg_tab_q[0].level;
          tick_clr  = 1'b1;
        end
      end

      RUN: begin
        if (seq.stop) begin
          state_d   = IDLE;
          seg_idx_d = '0;
          sig_d     = 1'b0;
        end else if (seg_end) begin
          // Next segment is loaded in the ending cycle: no gap on sig.
          tick_clr = 1'b1;
          ms_d     = '0;
          if (!last_seg) begin
            seg_idx_d = nxt_idx;
            sig_d     = seg_tab_q[nxt_idx].level;
          end else if (loop_more) begin
            seg_idx_d = '0;
            sig_d     = seg_tab_q[0].level;
          end else begin
            state_d   = DONE;
            seg_idx_d = '0;
            sig_d     = 1'b0;
          end
        end else if (tick) begin
          ms_d = ms_q + 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        sig_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      seg_idx_q <= '0;
      ms_q      <= '0;
      nseg_q    <= '0;
      sig_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      seg_idx_q <= seg_idx_d;
      ms_q      <= ms_d;
      nseg_q    <= nseg_d;
      sig_q     <= sig_d;
    end
  end

  assign seq.sig     = sig_q;
  assign seq.busy    = (state_q == RUN);
  assign seq.done    = (state_q == DONE);
  assign seq.seg_idx = seg_idx_q;

endmodule

// File: tb/tb_pattern_seq_ctrl.sv
// Scoreboard bench for pattern_seq_ctrl: the stimulus side queues the
// expected per-cycle sig/seg_idx trace and run outcome; a monitor checks them.
module tb_pattern_seq_ctrl;

  localparam int TC     = 4;
  localparam int DEPTH  = 8;
  localparam int DUR_W  = 8;
  localparam int LOOP_W = 4;

`ifdef PATTERN_SEQ_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  typedef struct { bit sig; int seg; } cyc_t;
  typedef struct { int len; bit done; } run_t;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  pattern_seq_ctrl_if #(.DEPTH(DEPTH), .DUR_W(DUR_W), .LOOP_W(LOOP_W)) seq();

  pattern_seq_ctrl #(
    .TICK_COUNT (TC),
    .DEPTH      (DEPTH),
    .DUR_W      (DUR_W),
    .LOOP_W     (LOOP_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .seq   (seq)
  );

  int   checks   = 0;
  int   failures = 0;
  cyc_t exp_cyc[$];
  run_t exp_run[$];
  bit   m_lvl[DEPTH];
  int   m_dur[DEPTH];
  bit   mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model: expand the table into the cycle-by-cycle waveform.
  function automatic int eff_dur(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  function automatic int nat_len(input int n, input int lp);
    int sum = 0;
    for (int s = 0; s < n; s++) sum += eff_dur(m_dur[s]) * TC;
    return sum * (LOOP_EN ? lp + 1 : 1);
  endfunction

  task automatic push_expect(input int n, input int lp, input int cut);
    int   total  = 0;
    int   passes = LOOP_EN ? lp + 1 : 1;
    cyc_t e;
    for (int p = 0; p < passes; p++)
      for (int s = 0; s < n; s++)
        for (int c = 0; c < eff_dur(m_dur[s]) * TC; c++)
          if (cut == 0 || total < cut) begin
            e.sig = m_lvl[s];
            e.seg = s;
            exp_cyc.push_back(e);
            total++;
          end
    exp_run.push_back('{len: total, done: (cut == 0)});
  endtask

  task automatic wr(input int a, input bit lvl, input int d, input bit apply);
    seq.cfg_we    = 1'b1;
    seq.cfg_addr  = 3'(a);
    seq.cfg_level = lvl;
    seq.cfg_dur   = 8'(d);
    cyc();
    seq.cfg_we = 1'b0;
    if (apply) begin
      m_lvl[a] = lvl;
      m_dur[a] = d;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sig"},     seq.sig,     0);
    check({tag, "_busy"},    seq.busy,    0);
    check({tag, "_done"},    seq.done,    0);
    check({tag, "_seg_idx"}, seq.seg_idx, 0);
  endtask

  // cut>0 ends the run after cut cycles via stop (or reset when by_rst).
  // bw>0 issues a table write plus a re-start in run cycle bw (both ignored).
  task automatic do_run(input int n, input int lp, input int cut, input bit by_rst,
                        input int bw, input bit retrig);
    push_expect(n, lp, cut);
    seq.num_seg = 4'(n);
    seq.loops   = 4'(lp);
    seq.start   = 1'b1;
    cyc();
    seq.start = 1'b0;
    if (cut > 0) begin
      repeat (cut - 1) cyc();
      if (by_rst) rst_n = 1'b0;
      else        seq.stop = 1'b1;
      cyc();
      if (by_rst) begin
        check_all_zero("midrun_reset");
        rst_n = 1'b1;
      end else begin
        seq.stop = 1'b0;
      end
      cyc();
      cyc();
    end else begin
      if (bw > 0) begin
        repeat (bw - 1) cyc();
        seq.cfg_we    = 1'b1;
        seq.cfg_addr  = 3'd0;
        seq.cfg_level = 1'b0;
        seq.cfg_dur   = 8'd5;
        seq.start     = 1'b1;
        cyc();
        seq.cfg_we = 1'b0;
        seq.start  = 1'b0;
      end
      for (int k = 0; k < 5000 && seq.busy === 1'b1; k++) cyc();
      check("run_timeout", seq.busy, 0);
      if (retrig) begin
        seq.start = 1'b1;
        cyc();
        seq.start = 1'b0;
        check("retrig_in_done_ignored", seq.busy, 0);
        cyc();
      end else begin
        cyc();
        cyc();
      end
    end
  endtask

  task automatic try_illegal(input int n, input bit with_stop, input string tag);
    seq.num_seg = 4'(n);
    seq.start   = 1'b1;
    seq.stop    = with_stop;
    cyc();
    seq.start = 1'b0;
    seq.stop  = 1'b0;
    check({tag, "_busy"}, seq.busy, 0);
    check({tag, "_sig"},  seq.sig,  0);
    cyc();
  endtask

  // Monitor: consume one expected cycle per busy cycle, close out each run
  // on the falling edge of busy, and flag any done outside that slot.
  int run_cnt   = 0;
  int mism      = 0;
  bit prev_busy = 1'b0;

  always @(negedge clk) begin : monitor
    cyc_t e;
    run_t r;
    if (mon_en) begin
      if (seq.busy === 1'b1) begin
        run_cnt++;
        if (exp_cyc.size() == 0) begin
          mism++;
        end else begin
          e = exp_cyc.pop_front();
          if (seq.sig !== e.sig || int'(seq.seg_idx) != e.seg) mism++;
        end
      end else if (prev_busy) begin
        if (exp_run.size() == 0) begin
          check("unexpected_run", run_cnt, 0);
        end else begin
          r = exp_run.pop_front();
          check("run_len", run_cnt, r.len);
          check("trace_mismatches", mism, 0);
          check("done_after_run", seq.done, r.done);
          check("sig_after_run", seq.sig, 0);
        end
        run_cnt = 0;
        mism    = 0;
      end else if (seq.done !== 1'b0) begin
        check("spurious_done", seq.done, 0);
      end
      prev_busy = (seq.busy === 1'b1);
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stimulus
    int n, lp, len, cut;
    rst_n         = 1'b0;
    seq.cfg_we    = 1'b0;
    seq.cfg_addr  = '0;
    seq.cfg_level = 1'b0;
    seq.cfg_dur   = '0;
    seq.num_seg   = '0;
    seq.loops     = '0;
    seq.start     = 1'b0;
    seq.stop      = 1'b0;
    repeat (3) cyc();
    check_all_zero("reset");
    rst_n = 1'b1;
    cyc();
    mon_en = 1'b1;

    // Basic three-segment pattern: 8 high, 4 low, 12 high.
    wr(0, 1'b1, 2, 1'b1);
    wr(1, 1'b0, 1, 1'b1);
    wr(2, 1'b1, 3, 1'b1);
    do_run(3, 0, 0, 1'b0, 0, 1'b0);

    // Repeats (72 or 24 cycles) with a re-trigger in the done cycle.
    do_run(3, 2, 0, 1'b0, 0, 1'b1);

    // Zero-duration segment behaves as one millisecond.
    wr(3, 1'b1, 0, 1'b1);
    wr(4, 1'b0, 1, 1'b1);
    do_run(5, 0, 0, 1'b0, 0, 1'b0);

    // Illegal counts and start+stop together are ignored.
    try_illegal(0, 1'b0, "num_seg0");
    try_illegal(9, 1'b0, "num_seg9");
    try_illegal(3, 1'b1, "start_stop");

    // Abort at run cycle 10, then a clean replay from segment 0.
    do_run(3, 0, 10, 1'b0, 0, 1'b0);
    do_run(3, 0, 0, 1'b0, 0, 1'b0);

    // Write and re-start while busy are dropped; the same write when idle lands.
    do_run(3, 0, 0, 1'b0, 5, 1'b0);
    wr(0, 1'b0, 5, 1'b1);
    do_run(3, 0, 0, 1'b0, 0, 1'b0);

    // Reset at run cycle 5 keeps the table; the next run replays it.
    do_run(3, 1, 5, 1'b1, 0, 1'b0);
    do_run(3, 0, 0, 1'b0, 0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      for (int a = 0; a < DEPTH; a++)
        wr(a, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'b1);
      n   = int'($urandom_range(1, DEPTH));
      lp  = int'($urandom_range(0, 3));
      len = nat_len(n, lp);
      cut = ($urandom_range(0, 3) == 0 && len > 1) ? int'($urandom_range(1, len - 1)) : 0;
      do_run(n, lp, cut, 1'b0, 0, 1'b0);
    end

    repeat (4) cyc();
    check("exp_cycles_drained", exp_cyc.size(), 0);
    check("exp_runs_drained", exp_run.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
